cdma_xbar_router: RTL
=====================

Name: cdma_xbar_router

Overview:
Parametrised, registered crossbar that succeeds the 1-to-4 combinational user demux. It connects NUM_IN source channels to NUM_OUT user channels with valid/ready handshakes on both sides. Each output has its own round-robin arbiter and a single-entry output register. It sits between the CDMA despreader outputs and the per-user sinks in the low-power router.

Parameters:
DATA_W, 4, payload width per channel
NUM_IN, 4, number of source channels (>=2)
NUM_OUT, 4, number of user output channels (>=2)
DEST_W, 2, destination field width; must be >= clog2(NUM_OUT)
SRC_W, 2, source index width; must be >= clog2(NUM_IN)
CNT_W, 8, width of the dropped-packet counter

Ports:
clk  in  1  system clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  NUM_IN  per-source request valid
in_data  in  NUM_IN*DATA_W  per-source payload; source i occupies bits [i*DATA_W +: DATA_W]
in_dest  in  NUM_IN*DEST_W  per-source destination user index, packed the same way
in_ready  out  NUM_IN  per-source accept; a transfer occurs when in_valid & in_ready
out_valid  out  NUM_OUT  output register holds data
out_data  out  NUM_OUT*DATA_W  registered payload per user
out_src  out  NUM_OUT*SRC_W  index of the source that produced out_data
out_ready  in  NUM_OUT  user sink accept
drop_cnt  out  CNT_W  saturating count of packets discarded for an invalid destination

Behaviour:
- Reset (async, while rst=1): out_valid=0, out_data=0, out_src=0, all RR pointers=0, drop_cnt=0. in_ready is forced to 0 while rst=1.
- Output slot o is free when !out_valid[o] | out_ready[o], so a full slot can be refilled in the same cycle it drains.
- Arbitration per output o (combinational):
  - Candidates are the inputs with in_valid[i] & in_dest[i]==o.
  - If slot o is free, grant the first candidate at or after ptr[o], searching upward with wrap modulo NUM_IN.
  - No grant is issued when the slot is not free.
- in_ready[i] = 1 when i is granted by its destination output, or when in_dest[i] >= NUM_OUT (drop path). Otherwise in_ready[i] = 0.
- On a grant for o at clock edge:
  - out_valid[o] <= 1; out_data[o] <= in_data[g]; out_src[o] <= g.
  - ptr[o] <= (g+1) mod NUM_IN.
- No grant but out_ready[o] & out_valid[o]: out_valid[o] <= 0. out_data and out_src hold their old values.
- Latency: accepted data appears on out_* on the next cycle. With out_ready held high, each output sustains 1 transfer/cycle.
- Different outputs are independent: up to min(NUM_IN, NUM_OUT) transfers per cycle.
- Source rule: in_data and in_dest must stay stable while in_valid=1 and in_ready=0.
- Backpressure: while out_valid[o]=1 and out_ready[o]=0, out_data[o] and out_src[o] stay stable and no source targeting o is accepted.
- Invalid destination (in_dest >= NUM_OUT, possible only when NUM_OUT < 2^DEST_W):
  - Packet is accepted and discarded.
  - drop_cnt increments by the number of such transfers that cycle.
  - drop_cnt saturates at all-ones.
- Pointers advance only on grant. An idle output keeps its pointer.
- Reset mid-operation: in-flight output data is lost and out_valid clears immediately (asynchronous). Operation resumes from the reset state on the first edge after rst falls.

Test Plan:
1. Reset then single transfer: in_valid=0001, in_data[0]=0xA, in_dest[0]=2, out_ready=all 1 -> in_ready[0]=1; next cycle out_valid=0100, out_data[2]=0xA, out_src[2]=0.
2. Contention: all 4 sources valid with dest=1, data 0x1..0x4, held until accepted, out_ready[1]=1 -> one grant per cycle. out_src[1] sequence is 0,1,2,3; data 0x1,0x2,0x3,0x4 on consecutive cycles; ptr[1] ends at 0.
3. Backpressure: out_valid[3]=1 with out_data=0x5, out_ready[3]=0, source 2 valid to dest 3 for 3 cycles -> in_ready[2]=0 and out_data[3]=0x5 stable. Raise out_ready -> same-cycle refill, next data appears one cycle later, no bubble.
4. Parallel: sources 0..3 to dests 3,2,1,0 simultaneously -> all in_ready=1. Next cycle all out_valid=1 with out_src = 3,2,1,0 for outputs 0..3.
5. Drop path, built with NUM_OUT=3: source 1 sends dest=3 for 5 transfers -> in_ready[1]=1 each cycle, no out_valid, drop_cnt=5. Force 260 drops with CNT_W=8 -> drop_cnt saturates at 255.
6. Reset mid-stream: assert rst asynchronously during the contention test -> out_valid=0 and in_ready=0 immediately, without a clock edge. After release, arbitration restarts from source 0.

Source files
------------

// File: rtl/cdma_xbar_router.sv
// Registered NUM_IN x NUM_OUT crossbar: per-output round-robin arbiter and one-entry output slot.
// Packets addressed past the last user are accepted, discarded and counted.
module cdma_xbar_router #(
    parameter int DATA_W  = 4,
    parameter int NUM_IN  = 4,
    parameter int NUM_OUT = 4,
    parameter int DEST_W  = 2,
    parameter int SRC_W   = 2,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN-1:0]         in_valid,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    input  logic [NUM_IN*DEST_W-1:0]  in_dest,
    output logic [NUM_IN-1:0]         in_ready,
    output logic [NUM_OUT-1:0]        out_valid,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT*SRC_W-1:0]  out_src,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [CNT_W-1:0]          drop_cnt
);

    logic [NUM_OUT-1:0]              out_valid_q, out_valid_d;
    logic [NUM_OUT-1:0][DATA_W-1:0]  out_data_q, out_data_d;
    logic [NUM_OUT-1:0][SRC_W-1:0]   out_src_q, out_src_d;
    logic [NUM_OUT-1:0][SRC_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]                drop_cnt_q, drop_cnt_d;

    logic [NUM_OUT-1:0]              free;
    logic [NUM_OUT-1:0]              gnt_vld;
    logic [NUM_OUT-1:0][SRC_W-1:0]   gnt_idx;
    logic [NUM_IN-1:0]               bad_dest;
    logic [CNT_W:0]                  drop_sum;
    int                              n_drop;

    // A full slot that drains this cycle may be refilled on the same edge
    assign free = ~out_valid_q | out_ready;

    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = '0;
        gnt_idx = '0;
        for (int o = 0; o < NUM_OUT; o++) begin
            if (free[o]) begin
                for (int k = 0; k < NUM_IN; k++) begin
                    idx = int'(ptr_q[o]) + k;
                    if (idx >= NUM_IN) idx = idx - NUM_IN;
                    if (!gnt_vld[o] && in_valid[idx] &&
                        in_dest[idx*DEST_W +: DEST_W] == DEST_W'(o)) begin
                        gnt_vld[o] = 1'b1;
                        gnt_idx[o] = SRC_W'(idx);
                    end
                end
            end
        end
    end

    always_comb begin
        logic rdy;
        rdy      = 1'b0;
        in_ready = '0;
        bad_dest = '0;
        n_drop   = 0;
        for (int i = 0; i < NUM_IN; i++) begin
            bad_dest[i] = {1'b0, in_dest[i*DEST_W +: DEST_W]}
                          >= (DEST_W+1)'(NUM_OUT);
            rdy = bad_dest[i];
            for (int o = 0; o < NUM_OUT; o++) begin
                if (gnt_vld[o] && gnt_idx[o] == SRC_W'(i)) rdy = 1'b1;
            end
            in_ready[i] = rdy & ~rst;
            if (in_valid[i] && bad_dest[i] && !rst) n_drop = n_drop + 1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        for (int o = 0; o < NUM_OUT; o++) begin
            if (gnt_vld[o]) begin
                out_valid_d[o] = 1'b1;
                out_data_d[o]  = in_data[int'(gnt_idx[o])*DATA_W +: DATA_W];
                out_src_d[o]   = gnt_idx[o];
                if (gnt_idx[o] == SRC_W'(NUM_IN-1)) ptr_d[o] = '0;
                else ptr_d[o] = gnt_idx[o] + SRC_W'(1);
            end else if (out_ready[o]) begin
                out_valid_d[o] = 1'b0;
            end
        end
        drop_sum   = {1'b0, drop_cnt_q} + (CNT_W+1)'(n_drop);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
            drop_cnt_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
